// File: rtl/btc_dec_iter_ctrl.sv
// Iteration scheduler for the BTC decoder array: alternates column/row halves with a flush gap.
// Optional early stop on a zero-error row half is enabled by BTC_DEC_ITER_CTRL_EARLY_STOP_EN.
module btc_dec_iter_ctrl #(
  parameter int pITER_W = 4,
  parameter int pERR_W  = 16,
  parameter int pFLUSH  = 4
) (
  input  logic               iclk,
  input  logic               ireset,
  input  logic               iclkena,
  input  logic               istart,
  input  logic [pITER_W-1:0] iNiter,
  input  logic               ihalf_done,
  input  logic               ibiterr_val,
  input  logic [pERR_W-1:0]  ibiterr,
  output logic               ordy,
  output logic               obusy,
  output logic               orow_mode,
  output logic               ohalf_start,
  output logic               olast_half,
  output logic [pITER_W-1:0] oiter,
  output logic               odone,
  output logic [pITER_W-1:0] oiter_used,
  output logic [pERR_W-1:0]  oerr,
  output logic [2:0]         ostate
);

  typedef enum logic [2:0] {
    IDLE, COL_START, COL_RUN, COL_FLUSH, ROW_START, ROW_RUN, ROW_FLUSH, DONE
  } state_t;

  localparam logic [7:0] FLUSH_INIT = 8'(pFLUSH);

  state_t             state;
  logic [pITER_W-1:0] niter;
  logic [7:0]         flush_cnt;
  logic [pERR_W-1:0]  err_q;
  logic               last_iter;
  logic               early_stop;
  logic               capture;

  assign last_iter = (oiter == niter - 1'b1);
  assign capture   = (state == COL_RUN) || (state == COL_FLUSH) ||
                     (state == ROW_RUN) || (state == ROW_FLUSH);

`ifdef BTC_DEC_ITER_CTRL_EARLY_STOP_EN
  assign early_stop = (err_q == '0);
`else
  assign early_stop = 1'b0;
`endif

  always_ff @(posedge iclk or negedge ireset) begin
    if (!ireset) begin
      state      <= IDLE;
      niter      <= {{(pITER_W-1){1'b0}}, 1'b1};
      flush_cnt  <= '0;
      err_q      <= '0;
      orow_mode  <= 1'b0;
      oiter      <= '0;
      oiter_used <= '0;
      oerr       <= '0;
    end else if (iclkena) begin
      // Last report within a half wins; START states clear it below.
      if (capture && ibiterr_val)
        err_q <= ibiterr;
      case (state)
        IDLE: begin
          if (istart) begin
            niter     <= (iNiter == '0) ? {{(pITER_W-1){1'b0}}, 1'b1} : iNiter;
            oiter     <= '0;
            orow_mode <= 1'b0;
            state     <= COL_START;
          end
        end
        COL_START: begin
          err_q <= '0;
          state <= COL_RUN;
        end
        COL_RUN: begin
          if (ihalf_done) begin
            flush_cnt <= FLUSH_INIT;
            state     <= COL_FLUSH;
          end
        end
        COL_FLUSH: begin
          if (flush_cnt == 8'd0) begin
            orow_mode <= 1'b1;
            state     <= ROW_START;
          end else begin
            flush_cnt <= flush_cnt - 8'd1;
          end
        end
        ROW_START: begin
          err_q <= '0;
          state <= ROW_RUN;
        end
        ROW_RUN: begin
          if (ihalf_done) begin
            flush_cnt <= FLUSH_INIT;
            state     <= ROW_FLUSH;
          end
        end
        ROW_FLUSH: begin
          if (flush_cnt == 8'd0) begin
            if (last_iter || early_stop) begin
              // Results are published on DONE entry so they are valid with odone.
              oiter_used <= oiter + 1'b1;
              oerr       <= err_q;
              state      <= DONE;
            end else begin
              oiter     <= oiter + 1'b1;
              orow_mode <= 1'b0;
              state     <= COL_START;
            end
          end else begin
            flush_cnt <= flush_cnt - 8'd1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign ordy        = (state == IDLE);
  assign obusy       = ~ordy;
  assign ohalf_start = (state == COL_START) || (state == ROW_START);
  assign odone       = (state == DONE);
  assign olast_half  = ((state == ROW_START) || (state == ROW_RUN) ||
                        (state == ROW_FLUSH)) && last_iter;
  assign ostate      = state;

endmodule

// File: doc/btc_dec_iter_ctrl.md
# btc_dec_iter_ctrl

Iteration scheduler for the BTC decoder component-code array. It sequences alternating column and row half-iterations and drives the array's row/column mode select. It starts each half-iteration and waits for the sink to finish writing, then allows a fixed pipeline-flush gap before switching mode. It captures the per-half bit-error count and ends decoding after the programmed number of iterations, or earlier on zero errors when early stop is compiled in.

## Interface

Parameters:
- pITER_W, 4, width of iteration count and index
- pERR_W, 16, width of bit-error count; matches the sink error counter
- pFLUSH, 4, extra idle cycles between half-iterations; range 0..255

Ports:
- iclk  in  1  clock
- ireset  in  1  reset; asynchronous and active-low
- iclkena  in  1  clock enable; all state, counters and registered outputs advance only when high
- istart  in  1  start pulse; accepted only when ordy=1
- iNiter  in  pITER_W  number of full iterations (col+row); latched at accepted istart; 0 is treated as 1
- ihalf_done  in  1  pulse from sink: last word of current half-iteration written
- ibiterr_val  in  1  ibiterr valid
- ibiterr  in  pERR_W  running error count of current half from sink
- ordy  out  1  idle, ready for istart
- obusy  out  1  decoding in progress (= !ordy)
- orow_mode  out  1  0 = column half, 1 = row half; to array irow_mode
- ohalf_start  out  1  one-cycle pulse; source starts feeding current half
- olast_half  out  1  current half is the final programmed row half
- oiter  out  pITER_W  current iteration index, 0-based
- odone  out  1  one-cycle pulse; decoding finished
- oiter_used  out  pITER_W  full iterations performed (1..Niter); valid from odone until next accepted istart
- oerr  out  pERR_W  error count captured in last row half; valid with oiter_used

## Operation

- FSM states: IDLE, COL_START, COL_RUN, COL_FLUSH, ROW_START, ROW_RUN, ROW_FLUSH, DONE.
- IDLE: when istart=1, latch max(iNiter,1), clear the iteration counter, and go to COL_START.
- COL_START / ROW_START:
  - Last exactly 1 cycle with ohalf_start=1.
  - Set orow_mode (0 / 1).
  - Clear the half error register.
- COL_RUN / ROW_RUN: wait for ihalf_done, then load the flush counter with pFLUSH and go to the matching FLUSH state.
- FLUSH: when the counter is 0, leave; otherwise decrement.
  - COL_FLUSH goes to ROW_START.
  - ROW_FLUSH goes to DONE if this is the last iteration (oiter = Niter-1) or the early-stop condition holds.
  - Otherwise ROW_FLUSH increments oiter and goes to COL_START.
- DONE:
  - Lasts 1 cycle with odone=1.
  - Update oiter_used to oiter+1 and oerr to the half error register.
  - Go to IDLE.
- Error capture: in RUN and FLUSH states, each ibiterr_val=1 overwrites the half error register with ibiterr, so the last report wins.
- orow_mode changes only on entry to a START state and holds through RUN and FLUSH; in IDLE/DONE it holds its last value.
- olast_half is high in ROW_START, ROW_RUN and ROW_FLUSH when oiter = Niter-1.
- Boundary conditions:
  - istart while busy is ignored.
  - ihalf_done outside RUN states is ignored.
  - ihalf_done and ibiterr_val in the same RUN cycle: both take effect.
  - pFLUSH=0 gives a 1-cycle FLUSH.
  - A reset mid-operation returns immediately to IDLE with reset values; no odone is produced.
- Reset values: state IDLE, ordy=1, obusy=0, orow_mode=0, ohalf_start=0, olast_half=0, oiter=0, odone=0, oiter_used=0, oerr=0.

## Timing

- Accepted istart in cycle t gives ohalf_start=1, orow_mode=0 in cycle t+1; ordy=0 from cycle t+1.
- ihalf_done in cycle d gives the next ohalf_start (or odone after the final row half) in cycle d+pFLUSH+2.
- ordy returns to 1 in the cycle after odone.
- With iclkena=0 all outputs hold, pulses included; a pulse lasts exactly one enabled cycle.

## Configuration

- BTC_DEC_ITER_CTRL_EARLY_STOP_EN defined: the early-stop condition is "half error register = 0 at ROW_FLUSH exit", which ends decoding before Niter iterations.
- Not defined: the early-stop condition is constant false, and exactly Niter iterations always run.

## Test plan

- Reset, then istart with iNiter=2, pFLUSH=4, ihalf_done 10 cycles after each ohalf_start -> orow_mode sequence 0,1,0,1; each ohalf_start 6 cycles after the preceding ihalf_done; odone once; oiter_used=2.
- iNiter=0 -> exactly one col and one row half; oiter_used=1; olast_half high during that row half.
- iNiter=3; row-half errors 5, 0, 7; macro defined -> odone after iteration 1, oiter_used=2, oerr=0. Macro undefined -> oiter_used=3, oerr=7.
- istart pulsed during ROW_RUN and ihalf_done pulsed during COL_START -> both ignored; sequence timing unchanged.
- iclkena held low for 3 cycles during COL_FLUSH -> ohalf_start delayed by exactly 3 cycles; odone still one enabled cycle wide.
- ireset asserted in ROW_RUN of iteration 1 -> all outputs at reset values immediately, no odone; new istart restarts at oiter=0, orow_mode=0.
